// File: rtl/game_pkg.sv
// Types and constants shared by the turn controller, scoring and display blocks.
// Phase encoding, winner codes and the frame counter width live here.
package game_pkg;

   localparam int FRAME_CNT_W = 12;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_CLEAR   = 3'd1,
      PH_P1_PLAY = 3'd2,
      PH_GAP     = 3'd3,
      PH_P2_PLAY = 3'd4,
      PH_DONE    = 3'd5
   } phase_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   function automatic logic [1:0] pick_winner(input logic [7:0] s1, input logic [7:0] s2);
      if (s1 > s2)      return WIN_P1;
      else if (s2 > s1) return WIN_P2;
      else              return WIN_TIE;
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable frame down-counter for one turn or gap; saturates at zero.
// Expire flags the enabled tick that consumes the last remaining frame.
module turn_timer
   import game_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_load,
   input  logic [FRAME_CNT_W-1:0] i_load_value,
   input  logic                   i_enable,
   output logic [FRAME_CNT_W-1:0] o_count,
   output logic                   o_expire
);

   logic [FRAME_CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_enable && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count  = r_count;
   assign o_expire = i_enable && (r_count == FRAME_CNT_W'(1));

endmodule

// File: rtl/turn_controller.sv
// Two-player turn sequencer: clear, P1 turn, gap, P2 turn, then winner decision.
// All outputs are registered copies of the values computed for the next state.
module turn_controller
   import game_pkg::*;
#(
   parameter int TURN_FRAMES = 1800,
   parameter int GAP_FRAMES  = 120
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_frame_tick,
   input  logic        i_start_req,
   input  logic        i_pause_req,
   input  logic [7:0]  i_score_1,
   input  logic [7:0]  i_score_2,
   output logic        o_player_flag,
   output logic        o_song_run,
   output logic        o_song_restart,
   output logic        o_score_clear,
   output logic [2:0]  o_phase,
   output logic [11:0] o_frames_left,
   output logic [1:0]  o_winner
);

   phase_t     r_state, w_next_state;
   logic       r_paused, w_next_paused;
   logic       r_player_flag, r_song_run, r_song_restart, r_score_clear;
   logic [1:0] r_winner, w_next_winner;

   logic                   w_load, w_enable, w_expire, w_change;
   logic [FRAME_CNT_W-1:0] w_load_value, w_count;

   assign w_enable = i_frame_tick && !r_paused;

   turn_timer u_timer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load       (w_load),
      .i_load_value (w_load_value),
      .i_enable     (w_enable),
      .o_count      (w_count),
      .o_expire     (w_expire)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_next_paused = r_paused;
      w_next_winner = r_winner;
      case (r_state)
         PH_IDLE:    if (i_start_req) w_next_state = PH_CLEAR;
         PH_CLEAR:   w_next_state = PH_P1_PLAY;
         PH_P1_PLAY: begin
            if (w_expire)         w_next_state  = PH_GAP;
            else if (i_pause_req) w_next_paused = !r_paused;
         end
         PH_GAP:     if (w_expire) w_next_state = PH_P2_PLAY;
         PH_P2_PLAY: begin
            if (w_expire) begin
               w_next_state  = PH_DONE;
               w_next_winner = pick_winner(i_score_1, i_score_2);
            end else if (i_pause_req) begin
               w_next_paused = !r_paused;
            end
         end
         PH_DONE:    if (i_start_req) w_next_state = PH_CLEAR;
         default:    w_next_state = PH_IDLE;
      endcase

      // Any phase change reloads the timer and drops a pending pause.
      w_change     = (w_next_state != r_state);
      w_load       = w_change;
      w_load_value = '0;
      if (w_change) begin
         w_next_paused = 1'b0;
         case (w_next_state)
            PH_P1_PLAY, PH_P2_PLAY: w_load_value = FRAME_CNT_W'(TURN_FRAMES);
            PH_GAP:                 w_load_value = FRAME_CNT_W'(GAP_FRAMES);
            default:                w_load_value = '0;
         endcase
         if (w_next_state == PH_CLEAR) w_next_winner = WIN_NONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= PH_IDLE;
         r_paused       <= 1'b0;
         r_winner       <= WIN_NONE;
         r_player_flag  <= 1'b1;
         r_song_run     <= 1'b0;
         r_song_restart <= 1'b0;
         r_score_clear  <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_paused       <= w_next_paused;
         r_winner       <= w_next_winner;
         r_player_flag  <= (w_next_state == PH_IDLE) || (w_next_state == PH_CLEAR) ||
                           (w_next_state == PH_P1_PLAY);
         r_song_run     <= ((w_next_state == PH_P1_PLAY) || (w_next_state == PH_P2_PLAY)) &&
                           !w_next_paused;
         r_song_restart <= w_change && ((w_next_state == PH_CLEAR) || (w_next_state == PH_GAP));
         r_score_clear  <= w_change && (w_next_state == PH_CLEAR);
      end
   end

   assign o_phase        = r_state;
   assign o_frames_left  = w_count;
   assign o_winner       = r_winner;
   assign o_player_flag  = r_player_flag;
   assign o_song_run     = r_song_run;
   assign o_song_restart = r_song_restart;
   assign o_score_clear  = r_score_clear;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller with TURN_FRAMES=3, GAP_FRAMES=2: vector table,
// directed corner sequences, then random stimulus against a game-level model.
module tb_turn_controller;
   import game_pkg::*;

   localparam int TURN = 3;
   localparam int GAP  = 2;

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_frame_tick = 1'b0, i_start_req = 1'b0, i_pause_req = 1'b0;
   logic [7:0]  i_score_1 = '0, i_score_2 = '0;
   logic        o_player_flag, o_song_run, o_song_restart, o_score_clear;
   logic [2:0]  o_phase;
   logic [11:0] o_frames_left;
   logic [1:0]  o_winner;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk = ~clk;

   turn_controller #(.TURN_FRAMES(TURN), .GAP_FRAMES(GAP)) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_frame_tick   (i_frame_tick),
      .i_start_req    (i_start_req),
      .i_pause_req    (i_pause_req),
      .i_score_1      (i_score_1),
      .i_score_2      (i_score_2),
      .o_player_flag  (o_player_flag),
      .o_song_run     (o_song_run),
      .o_song_restart (o_song_restart),
      .o_score_clear  (o_score_clear),
      .o_phase        (o_phase),
      .o_frames_left  (o_frames_left),
      .o_winner       (o_winner)
   );

   // Game-level model: which phase we are in, frames remaining, pause, result.
   logic [2:0] m_phase = PH_IDLE;
   int         m_left = 0;
   bit         m_paused = 0, m_restart = 0, m_clear = 0;
   logic [1:0] m_winner = 2'b00;

   function automatic bit m_flag();
      return (m_phase == PH_IDLE) || (m_phase == PH_CLEAR) || (m_phase == PH_P1_PLAY);
   endfunction

   function automatic bit m_run();
      return ((m_phase == PH_P1_PLAY) || (m_phase == PH_P2_PLAY)) && !m_paused;
   endfunction

   task automatic model_step(input bit rst, input bit st, input bit pa, input bit tk,
                             input int s1, input int s2);
      bit counts;
      m_restart = 0;
      m_clear   = 0;
      if (rst) begin
         m_phase = PH_IDLE; m_left = 0; m_paused = 0; m_winner = 2'b00;
         return;
      end
      counts = tk && !m_paused;
      case (m_phase)
         PH_IDLE, PH_DONE: if (st) begin
            m_phase = PH_CLEAR; m_left = 0; m_restart = 1; m_clear = 1; m_winner = 2'b00;
         end
         PH_CLEAR: begin m_phase = PH_P1_PLAY; m_left = TURN; end
         PH_GAP: begin
            if (tk && m_left == 1) begin m_phase = PH_P2_PLAY; m_left = TURN; end
            else if (tk && m_left > 0) m_left--;
         end
         default: begin
            if (counts && m_left == 1) begin
               m_paused = 0;
               if (m_phase == PH_P1_PLAY) begin
                  m_phase = PH_GAP; m_left = GAP; m_restart = 1;
               end else begin
                  m_phase = PH_DONE; m_left = 0;
                  m_winner = (s1 > s2) ? 2'b01 : (s2 > s1) ? 2'b10 : 2'b11;
               end
            end else begin
               if (counts && m_left > 0) m_left--;
               if (pa) m_paused = !m_paused;
            end
         end
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle(input bit rst, input bit st, input bit pa, input bit tk);
      @(negedge clk);
      i_reset = rst; i_start_req = st; i_pause_req = pa; i_frame_tick = tk;
      @(posedge clk);
      model_step(rst, st, pa, tk, int'(i_score_1), int'(i_score_2));
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " phase"},   int'(o_phase),        int'(m_phase));
      check({tag, " left"},    int'(o_frames_left),  m_left);
      check({tag, " flag"},    int'(o_player_flag),  int'(m_flag()));
      check({tag, " run"},     int'(o_song_run),     int'(m_run()));
      check({tag, " restart"}, int'(o_song_restart), int'(m_restart));
      check({tag, " clear"},   int'(o_score_clear),  int'(m_clear));
      check({tag, " winner"},  int'(o_winner),       int'(m_winner));
   endtask

   typedef struct {
      bit         st, pa, tk;
      int         s1, s2;
      logic [2:0] phase;
      int         left;
      bit         flag, run, restart, clear;
      logic [1:0] winner;
   } vec_t;

   vec_t vecs[13];

   initial begin
      //              st pa tk s1 s2 phase       left fl run rs cl win
      vecs[0]  = '{1, 0, 0, 0, 0, PH_CLEAR,   0, 1, 0, 1, 1, 2'b00};
      vecs[1]  = '{0, 0, 0, 0, 0, PH_P1_PLAY, 3, 1, 1, 0, 0, 2'b00};
      vecs[2]  = '{0, 0, 1, 0, 0, PH_P1_PLAY, 2, 1, 1, 0, 0, 2'b00};
      vecs[3]  = '{0, 0, 1, 0, 0, PH_P1_PLAY, 1, 1, 1, 0, 0, 2'b00};
      vecs[4]  = '{0, 0, 1, 0, 0, PH_GAP,     2, 0, 0, 1, 0, 2'b00};
      vecs[5]  = '{0, 0, 0, 0, 0, PH_GAP,     2, 0, 0, 0, 0, 2'b00};
      vecs[6]  = '{0, 0, 1, 0, 0, PH_GAP,     1, 0, 0, 0, 0, 2'b00};
      vecs[7]  = '{0, 0, 1, 0, 0, PH_P2_PLAY, 3, 0, 1, 0, 0, 2'b00};
      vecs[8]  = '{0, 0, 1, 0, 0, PH_P2_PLAY, 2, 0, 1, 0, 0, 2'b00};
      vecs[9]  = '{0, 0, 1, 0, 0, PH_P2_PLAY, 1, 0, 1, 0, 0, 2'b00};
      vecs[10] = '{0, 0, 1, 5, 3, PH_DONE,    0, 0, 0, 0, 0, 2'b01};
      vecs[11] = '{0, 1, 1, 1, 9, PH_DONE,    0, 0, 0, 0, 0, 2'b01};
      vecs[12] = '{1, 0, 0, 0, 0, PH_CLEAR,   0, 1, 0, 1, 1, 2'b00};

      // Reset state
      cycle(1, 0, 0, 0);
      check("rst phase",   int'(o_phase), int'(PH_IDLE));
      check("rst left",    int'(o_frames_left), 0);
      check("rst flag",    int'(o_player_flag), 1);
      check("rst run",     int'(o_song_run), 0);
      check("rst restart", int'(o_song_restart), 0);
      check("rst clear",   int'(o_score_clear), 0);
      check("rst winner",  int'(o_winner), 0);
      cycle(0, 0, 0, 1);
      check("idle tick ignored", int'(o_frames_left), 0);

      // Full game from the vector table
      for (int i = 0; i < 13; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         i_score_1 = 8'(vecs[i].s1);
         i_score_2 = 8'(vecs[i].s2);
         cycle(0, vecs[i].st, vecs[i].pa, vecs[i].tk);
         check({tag, " phase"},   int'(o_phase),        int'(vecs[i].phase));
         check({tag, " left"},    int'(o_frames_left),  vecs[i].left);
         check({tag, " flag"},    int'(o_player_flag),  int'(vecs[i].flag));
         check({tag, " run"},     int'(o_song_run),     int'(vecs[i].run));
         check({tag, " restart"}, int'(o_song_restart), int'(vecs[i].restart));
         check({tag, " clear"},   int'(o_score_clear),  int'(vecs[i].clear));
         check({tag, " winner"},  int'(o_winner),       int'(vecs[i].winner));
      end

      // Tie game: scores 4/4 at P2 expiry
      cycle(0, 0, 0, 0);
      for (int i = 0; i < TURN + GAP; i++) cycle(0, 0, 0, 1);
      check("tie in P2", int'(o_phase), int'(PH_P2_PLAY));
      i_score_1 = 8'd4; i_score_2 = 8'd4;
      for (int i = 0; i < TURN; i++) cycle(0, 0, 0, 1);
      check("tie phase",  int'(o_phase), int'(PH_DONE));
      check("tie winner", int'(o_winner), 3);

      // start_req and frame_tick together in DONE: start wins
      cycle(0, 1, 0, 1);
      check("start+tick phase", int'(o_phase), int'(PH_CLEAR));
      cycle(0, 0, 0, 1);
      check("clear->P1 left", int'(o_frames_left), TURN);

      // Pause holds the count for several ticks, second pause resumes
      cycle(0, 0, 0, 1);
      check("pre-pause left", int'(o_frames_left), 2);
      cycle(0, 0, 1, 0);
      check("paused run", int'(o_song_run), 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
      check("paused left", int'(o_frames_left), 2);
      check("paused run held", int'(o_song_run), 0);
      cycle(0, 0, 1, 0);
      check("resume run", int'(o_song_run), 1);
      cycle(0, 0, 0, 1);
      check("resume left", int'(o_frames_left), 1);

      // Pause coincident with expiring tick: expiry wins
      cycle(0, 0, 1, 1);
      check("coinc phase",   int'(o_phase), int'(PH_GAP));
      check("coinc run",     int'(o_song_run), 0);
      check("coinc restart", int'(o_song_restart), 1);
      cycle(0, 0, 1, 1);
      check("gap ticks",  int'(o_frames_left), 1);
      cycle(0, 0, 0, 1);
      check("gap->P2",    int'(o_phase), int'(PH_P2_PLAY));
      check("P2 run",     int'(o_song_run), 1);

      // start_req ignored mid-P2, then reset mid-P2
      cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 0);
      check("P2 start ignored phase", int'(o_phase), int'(PH_P2_PLAY));
      check("P2 start ignored left",  int'(o_frames_left), 2);
      cycle(1, 1, 1, 1);
      check_model("midreset");
      check("midreset phase", int'(o_phase), int'(PH_IDLE));
      check("midreset flag",  int'(o_player_flag), 1);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         bit rst, st, pa, tk;
         rst = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 29) == 0);
         pa  = ($urandom_range(0, 9) == 0);
         tk  = ($urandom_range(0, 9) < 4);
         i_score_1 = 8'($urandom_range(0, 7));
         i_score_2 = 8'($urandom_range(0, 7));
         cycle(rst, st, pa, tk);
         check_model($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
